// File: rtl/usb_packet_arbiter_pkg.sv
// usb_packet_arbiter shared types: packet type codes, packet bundle, FSM states.
// Build option: define ARB_OVF_MARKER_EN to add the S_MARK overflow-marker state.
package usb_packet_arbiter_pkg;

    localparam int PKT_TYPE_W    = 2;
    localparam int PKT_PAYLOAD_W = 23;
    localparam int PKT_W         = PKT_TYPE_W + PKT_PAYLOAD_W;

    typedef enum logic [PKT_TYPE_W-1:0] {
        PKT_ADDR  = 2'b00,
        PKT_READ  = 2'b01,
        PKT_WRITE = 2'b10,
        PKT_TIME  = 2'b11
    } pkt_type_e;

    typedef struct packed {
        pkt_type_e                ptype;
        logic [PKT_PAYLOAD_W-1:0] payload;
    } pkt_t;

`ifdef ARB_OVF_MARKER_EN
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MARK = 1'b1
    } arb_state_e;
`else
    typedef enum logic [0:0] {
        S_IDLE = 1'b0
    } arb_state_e;
`endif

endpackage

// File: rtl/usb_packet_arbiter_pkt_fifo.sv
// pkt_fifo: synchronous first-word-fall-through FIFO for trace packets.
// Ports: mclk/reset (async, active-high), push/wdata, pop/rdata, full, empty, level.
module pkt_fifo
    import usb_packet_arbiter_pkg::*;
#(
    parameter int W  = PKT_W,
    parameter int AW = 2
) (
    input  logic         mclk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  level
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_d;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [AW:0]   level_q;
    logic [AW:0]   level_d;
    logic          push_en;
    logic          pop_en;

    assign empty   = (level_q == '0);
    assign full    = (level_q == (AW+1)'(DEPTH));
    assign pop_en  = pop && !empty;
    // A full FIFO still accepts a push when an entry leaves in the same cycle.
    assign push_en = push && (!full || pop_en);
    assign rdata   = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_en) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_en, pop_en})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/usb_packet_arbiter.sv
// usb_packet_arbiter: merges buffered trace packets and round-robin requesters
// onto one registered USB packet stream, with saturating trace drop counting.
// Ports: mclk, reset (async, active-high); trace_strobe/type/payload in;
// req_valid/type/payload in, req_ack out; out_ready in;
// packet_strobe/type/payload out; drop_count, trace_level out.
// Build option: ARB_OVF_MARKER_EN emits one OVF_MARKER packet after drops.
module usb_packet_arbiter
    import usb_packet_arbiter_pkg::*;
#(
    parameter int NREQ        = 2,
`ifdef ARB_OVF_MARKER_EN
    parameter logic [22:0] OVF_MARKER = 23'h7FFFFF,
`endif
    parameter int TDEPTH_LOG2 = 2
) (
    input  logic                 mclk,
    input  logic                 reset,
    input  logic                 trace_strobe,
    input  logic [1:0]           trace_type,
    input  logic [22:0]          trace_payload,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [2*NREQ-1:0]    req_type,
    input  logic [23*NREQ-1:0]   req_payload,
    output logic [NREQ-1:0]      req_ack,
    input  logic                 out_ready,
    output logic                 packet_strobe,
    output logic [1:0]           packet_type,
    output logic [22:0]          packet_payload,
    output logic [15:0]          drop_count,
    output logic [TDEPTH_LOG2:0] trace_level
);

    localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e      state_q;
    arb_state_e      state_d;
    logic [RW-1:0]   rr_ptr_q;
    logic [RW-1:0]   rr_ptr_d;
    logic            strobe_q;
    logic            strobe_d;
    pkt_t            pkt_q;
    pkt_t            pkt_d;
    logic [15:0]     drop_cnt_q;
    logic [15:0]     drop_cnt_d;

    pkt_t            fifo_wdata;
    pkt_t            fifo_rdata;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic            drop;

    logic            gnt_found;
    logic [RW-1:0]   gnt_idx;
    logic [NREQ-1:0] ack_c;

`ifdef ARB_OVF_MARKER_EN
    logic            ovf_pending_q;
    logic            ovf_pending_d;
    logic            mark_done;
`endif

    assign fifo_wdata = '{ptype:   pkt_type_e'(trace_type),
                          payload: trace_payload};
    assign drop = trace_strobe && fifo_full && !fifo_pop;

    pkt_fifo #(
        .W  (PKT_W),
        .AW (TDEPTH_LOG2)
    ) u_trace_fifo (
        .mclk  (mclk),
        .reset (reset),
        .push  (trace_strobe),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (trace_level)
    );

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_found &&
                req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
                gnt_found = 1'b1;
                gnt_idx   = RW'((int'(rr_ptr_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        strobe_d = 1'b0;
        pkt_d    = pkt_q;
        fifo_pop = 1'b0;
        ack_c    = '0;
`ifdef ARB_OVF_MARKER_EN
        mark_done = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (out_ready && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    pkt_d    = fifo_rdata;
                    strobe_d = 1'b1;
`ifdef ARB_OVF_MARKER_EN
                end else if (out_ready && ovf_pending_q) begin
                    state_d = S_MARK;
`endif
                // A trace strobe arriving now is owed the next slot,
                // so requesters wait until it has been drained.
                end else if (out_ready && !trace_strobe
                             && gnt_found) begin
                    ack_c[gnt_idx] = 1'b1;
                    pkt_d.ptype    = pkt_type_e'(
                        req_type[2*int'(gnt_idx) +: 2]);
                    pkt_d.payload  =
                        req_payload[23*int'(gnt_idx) +: 23];
                    strobe_d       = 1'b1;
                    rr_ptr_d       =
                        RW'((int'(gnt_idx) + 1) % NREQ);
                end
            end
`ifdef ARB_OVF_MARKER_EN
            S_MARK: begin
                if (out_ready) begin
                    pkt_d.ptype   = PKT_ADDR;
                    pkt_d.payload = OVF_MARKER;
                    strobe_d      = 1'b1;
                    mark_done     = 1'b1;
                    state_d       = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

`ifdef ARB_OVF_MARKER_EN
    // A drop in the marker cycle re-arms the flag for another marker.
    always_comb begin
        ovf_pending_d = ovf_pending_q;
        if (mark_done) begin
            ovf_pending_d = 1'b0;
        end
        if (drop) begin
            ovf_pending_d = 1'b1;
        end
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            ovf_pending_q <= 1'b0;
        end else begin
            ovf_pending_q <= ovf_pending_d;
        end
    end
`endif

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            strobe_q   <= 1'b0;
            pkt_q      <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            strobe_q   <= strobe_d;
            pkt_q      <= pkt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Ack is combinational; hold it low while reset is asserted.
    assign req_ack        = ack_c & {NREQ{~reset}};
    assign packet_strobe  = strobe_q;
    assign packet_type    = pkt_q.ptype;
    assign packet_payload = pkt_q.payload;
    assign drop_count     = drop_cnt_q;

endmodule
